// File: rtl/bounce_counter_gen_if.sv
// ---------------------------------------------------------------------------
// bounce_counter_gen_if
//   Control/status bundle for the LED pattern counter.
//   master : drives enable, mode, lo, hi, load, load_val; observes count,
//            dir, tick, turn (board controller / testbench side)
//   slave  : the counter itself
// ---------------------------------------------------------------------------
interface bounce_counter_gen_if #(
  parameter int WIDTH = 6
);
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tick;
  logic             turn;

  modport master (
    output enable, mode, lo, hi, load, load_val,
    input  count, dir, tick, turn
  );

  modport slave (
    input  enable, mode, lo, hi, load, load_val,
    output count, dir, tick, turn
  );
endinterface

// File: rtl/bounce_counter_gen.sv
// ---------------------------------------------------------------------------
// bounce_counter_gen
//   LED pattern counter. A WIDTH-bit count steps once every
//   2**PRESCALE_BITS enabled clock cycles, in bounce, wrap-up, wrap-down or
//   hold mode between inclusive lo/hi limits. The prescaler is only a clock
//   enable; everything runs on clk.
// Ports
//   clk  : system clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : slave side of bounce_counter_gen_if
//          enable, mode, lo, hi, load, load_val in;
//          count, dir, tick, turn out (all registered)
// ---------------------------------------------------------------------------
module bounce_counter_gen #(
  parameter int WIDTH         = 6,
  parameter int PRESCALE_BITS = 22,
  parameter int INIT          = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bounce_counter_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0]         INIT_VAL = WIDTH'(INIT);
  localparam logic [WIDTH-1:0]         CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_BITS-1:0] PS_ONE   = PRESCALE_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] PS_ZERO  = PRESCALE_BITS'(0);
  localparam logic [PRESCALE_BITS-1:0] PS_LAST  = {PRESCALE_BITS{1'b1}};

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [PRESCALE_BITS-1:0] prescale_r;
  logic [WIDTH-1:0]         count_r;
  logic                     dir_r;
  logic                     tick_r;
  logic                     turn_r;

  logic                     step_s;
  logic [WIDTH-1:0]         next_count_s;
  logic                     next_dir_s;
  logic                     next_turn_s;
  mode_e                    mode_s;

  // A step happens on the enabled edge where the prescaler rolls over.
  assign step_s = bus.enable && (prescale_r == PS_LAST);
  assign mode_s = mode_e'(bus.mode);

  // Next count/dir/turn for a step; limits and mode only matter here.
  always_comb begin
    next_count_s = count_r;
    next_dir_s   = dir_r;
    next_turn_s  = 1'b0;
    if (bus.lo >= bus.hi) begin
      // Degenerate window: park on lo, keep direction.
      next_count_s = bus.lo;
    end else if (count_r > bus.hi) begin
      // Out-of-range recovery consumes the step.
      next_count_s = bus.hi;
    end else if (count_r < bus.lo) begin
      next_count_s = bus.lo;
    end else begin
      case (mode_s)
        MODE_BOUNCE: begin
          if (dir_r) begin
            if (count_r == bus.hi) begin
              // Reverse immediately so a limit is never held for two steps.
              next_dir_s   = 1'b0;
              next_count_s = bus.hi - CNT_ONE;
              next_turn_s  = 1'b1;
            end else begin
              next_count_s = count_r + CNT_ONE;
            end
          end else begin
            if (count_r == bus.lo) begin
              next_dir_s   = 1'b1;
              next_count_s = bus.lo + CNT_ONE;
              next_turn_s  = 1'b1;
            end else begin
              next_count_s = count_r - CNT_ONE;
            end
          end
        end
        MODE_UP: begin
          next_dir_s = 1'b1;
          if (count_r == bus.hi) begin
            next_count_s = bus.lo;
          end else begin
            next_count_s = count_r + CNT_ONE;
          end
        end
        MODE_DOWN: begin
          next_dir_s = 1'b0;
          if (count_r == bus.lo) begin
            next_count_s = bus.hi;
          end else begin
            next_count_s = count_r - CNT_ONE;
          end
        end
        MODE_HOLD: begin
          next_count_s = count_r;
        end
        default: begin
          next_count_s = count_r;
        end
      endcase
    end
  end

  // Prescaler, count, direction and the one-cycle tick/turn pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_r <= PS_ZERO;
      count_r    <= INIT_VAL;
      dir_r      <= 1'b1;
      tick_r     <= 1'b0;
      turn_r     <= 1'b0;
    end else if (bus.load) begin
      // Load wins over a coincident step and restarts the period.
      prescale_r <= PS_ZERO;
      count_r    <= bus.load_val;
      tick_r     <= 1'b0;
      turn_r     <= 1'b0;
    end else if (bus.enable) begin
      prescale_r <= prescale_r + PS_ONE;
      if (step_s) begin
        count_r <= next_count_s;
        dir_r   <= next_dir_s;
        tick_r  <= 1'b1;
        turn_r  <= next_turn_s;
      end else begin
        tick_r  <= 1'b0;
        turn_r  <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
      turn_r <= 1'b0;
    end
  end

  assign bus.count = count_r;
  assign bus.dir   = dir_r;
  assign bus.tick  = tick_r;
  assign bus.turn  = turn_r;

endmodule

// File: tb/tb_bounce_counter_gen.sv
// ---------------------------------------------------------------------------
// tb_bounce_counter_gen
//   Directed bench for bounce_counter_gen with WIDTH=4, PRESCALE_BITS=2,
//   INIT=3. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bounce_counter_gen;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  bounce_counter_gen_if #(.WIDTH(4)) bus ();

  bounce_counter_gen #(
    .WIDTH(4),
    .PRESCALE_BITS(2),
    .INIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for the next tick; cycles = falling edges until seen, -1 on timeout.
  task automatic wait_tick(input int max_cycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    bus.enable = 1'b1; bus.mode = 2'b00; bus.lo = 4'd0; bus.hi = 4'd5;
    bus.load = 1'b0; bus.load_val = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_load(4'd9);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.count !== 4'd3) $display("FAIL reset_count got %0d want 3", bus.count); else passed++;
    total++; if (bus.dir !== 1'b1) $display("FAIL reset_dir got %b want 1", bus.dir); else passed++;
    total++; if (bus.tick !== 1'b0) $display("FAIL reset_tick got %b want 0", bus.tick); else passed++;
    @(negedge clk);
    rst = 1'b0;
    wait_tick(10, c);
    total++; if (c !== 4) $display("FAIL reset_first_tick got %0d cycles want 4", c); else passed++;
    total++; if (bus.count !== 4'd4) $display("FAIL reset_first_step got %0d want 4", bus.count); else passed++;
  endtask

  task automatic test_bounce();
    logic [3:0] exp_c [8] = '{4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
    logic       exp_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_d [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int c;
    bus.mode = 2'b00; bus.lo = 4'd0; bus.hi = 4'd5;
    do_load(4'd3);
    for (int i = 0; i < 8; i++) begin
      wait_tick(10, c);
      total++; if (c !== 4) $display("FAIL bounce_period[%0d] got %0d want 4", i, c); else passed++;
      total++; if (bus.count !== exp_c[i]) $display("FAIL bounce_count[%0d] got %0d want %0d", i, bus.count, exp_c[i]); else passed++;
      total++; if (bus.turn !== exp_t[i]) $display("FAIL bounce_turn[%0d] got %b want %b", i, bus.turn, exp_t[i]); else passed++;
      total++; if (bus.dir !== exp_d[i]) $display("FAIL bounce_dir[%0d] got %b want %b", i, bus.dir, exp_d[i]); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] up_c [4] = '{4'd4, 4'd2, 4'd3, 4'd4};
    logic [3:0] dn_c [4] = '{4'd3, 4'd2, 4'd4, 4'd3};
    int c;
    bus.mode = 2'b01; bus.lo = 4'd2; bus.hi = 4'd4;
    do_load(4'd3);
    for (int i = 0; i < 4; i++) begin
      wait_tick(10, c);
      total++; if (bus.count !== up_c[i]) $display("FAIL wrap_up_count[%0d] got %0d want %0d", i, bus.count, up_c[i]); else passed++;
      total++; if (bus.dir !== 1'b1 || bus.turn !== 1'b0) $display("FAIL wrap_up_dirturn[%0d] got %b%b want 10", i, bus.dir, bus.turn); else passed++;
    end
    bus.mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      wait_tick(10, c);
      total++; if (bus.count !== dn_c[i]) $display("FAIL wrap_down_count[%0d] got %0d want %0d", i, bus.count, dn_c[i]); else passed++;
      total++; if (bus.dir !== 1'b0 || bus.turn !== 1'b0) $display("FAIL wrap_down_dirturn[%0d] got %b%b want 00", i, bus.dir, bus.turn); else passed++;
    end
  endtask

  task automatic test_load_step();
    logic [3:0] exp_c [3] = '{4'd5, 4'd4, 4'd3};
    int c;
    bus.mode = 2'b00; bus.lo = 4'd0; bus.hi = 4'd5;
    // Three more edges bring the prescaler to its last value.
    repeat (3) @(negedge clk);
    do_load(4'd12);
    total++; if (bus.count !== 4'd12) $display("FAIL load_step_count got %0d want 12", bus.count); else passed++;
    total++; if (bus.tick !== 1'b0) $display("FAIL load_step_tick got %b want 0", bus.tick); else passed++;
    for (int i = 0; i < 3; i++) begin
      wait_tick(10, c);
      total++; if (c !== 4) $display("FAIL load_period[%0d] got %0d want 4", i, c); else passed++;
      total++; if (bus.count !== exp_c[i]) $display("FAIL load_follow_count[%0d] got %0d want %0d", i, bus.count, exp_c[i]); else passed++;
      total++; if (bus.turn !== 1'b0 || bus.dir !== 1'b0) $display("FAIL load_follow_dirturn[%0d] got %b%b want 00", i, bus.dir, bus.turn); else passed++;
    end
  endtask

  task automatic test_enable_freeze();
    int c;
    repeat (2) @(negedge clk);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.tick !== 1'b0 || bus.count !== 4'd3)
        $display("FAIL freeze[%0d] got tick=%b count=%0d want tick=0 count=3", i, bus.tick, bus.count);
      else passed++;
    end
    bus.enable = 1'b1;
    wait_tick(10, c);
    total++; if (c !== 2) $display("FAIL freeze_resume got %0d cycles want 2", c); else passed++;
    total++; if (bus.count !== 4'd2) $display("FAIL freeze_resume_count got %0d want 2", bus.count); else passed++;
  endtask

  task automatic test_degenerate();
    int c;
    bus.lo = 4'd7; bus.hi = 4'd7;
    for (int i = 0; i < 2; i++) begin
      wait_tick(10, c);
      total++; if (bus.count !== 4'd7) $display("FAIL equal_limits[%0d] got %0d want 7", i, bus.count); else passed++;
      total++; if (bus.turn !== 1'b0 || bus.dir !== 1'b0) $display("FAIL equal_dirturn[%0d] got %b%b want 00", i, bus.dir, bus.turn); else passed++;
    end
    bus.lo = 4'd9; bus.hi = 4'd2;
    for (int i = 0; i < 2; i++) begin
      wait_tick(10, c);
      total++; if (bus.count !== 4'd9) $display("FAIL inverted_limits[%0d] got %0d want 9", i, bus.count); else passed++;
      total++; if (bus.turn !== 1'b0) $display("FAIL inverted_turn[%0d] got %b want 0", i, bus.turn); else passed++;
    end
  endtask

  task automatic test_hold();
    int c;
    bus.mode = 2'b11; bus.lo = 4'd0; bus.hi = 4'd5;
    do_load(4'd4);
    for (int i = 0; i < 2; i++) begin
      wait_tick(10, c);
      total++; if (c !== 4) $display("FAIL hold_tick[%0d] got %0d cycles want 4", i, c); else passed++;
      total++; if (bus.count !== 4'd4) $display("FAIL hold_count[%0d] got %0d want 4", i, bus.count); else passed++;
      total++; if (bus.dir !== 1'b0 || bus.turn !== 1'b0) $display("FAIL hold_dirturn[%0d] got %b%b want 00", i, bus.dir, bus.turn); else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    test_reset();
    test_bounce();
    test_wrap();
    test_load_step();
    test_enable_freeze();
    test_degenerate();
    test_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
